// File: rtl/pwm_motor_ctrl.sv
// pwm_motor_ctrl: sequences two PWM channels from signed speed commands with reversal dead time and brake.
// Define PWM_MOTOR_CTRL_RAMP_EN for STEP-per-tick slew limiting; without it each tick jumps straight to the target.
module pwm_motor_ctrl #(
    parameter int PERIOD_CYC = 1024,
    parameter int STEP       = 16,
    parameter int DEAD_TICKS = 4,
    parameter int DUTY_MAX   = 1022
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_vld,
    output logic        cmd_rdy,
    input  logic [10:0] cmd_lft,
    input  logic [10:0] cmd_rht,
    input  logic        brake,
    output logic [9:0]  duty_lft,
    output logic [9:0]  duty_rht,
    output logic        en_lft,
    output logic        en_rht,
    output logic        rev_lft,
    output logic        rev_rht,
    output logic        busy,
    output logic [3:0]  dbg_state
);

    localparam int PW = $clog2(PERIOD_CYC);
    localparam int DW = $clog2(DEAD_TICKS + 1);
`ifdef PWM_MOTOR_CTRL_RAMP_EN
    localparam logic [10:0] STEP_W = 11'(STEP);
`else
    localparam logic [10:0] STEP_W = 11'h7ff;
`endif

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    logic [PW-1:0] presc_q, presc_d;
    logic          tick;
    logic          accept;
    logic [10:0]   cmd_a     [2];
    state_t        state_q   [2];
    state_t        state_d   [2];
    logic [9:0]    cur_q     [2];
    logic [9:0]    cur_d     [2];
    logic          rev_q     [2];
    logic          rev_d     [2];
    logic [DW-1:0] dcnt_q    [2];
    logic [DW-1:0] dcnt_d    [2];
    logic          tgt_dir_q [2];
    logic          tgt_dir_d [2];
    logic [9:0]    tgt_mag_q [2];
    logic [9:0]    tgt_mag_d [2];
    logic [1:0]    settled;

    // |cmd| limited to DUTY_MAX; -1024 has magnitude 1024 at 11 bits and clamps like the rest.
    function automatic logic [9:0] clamp_mag(input logic [10:0] c);
        logic [10:0] a;
        a = c[10] ? (~c + 11'd1) : c;
        return (a > 11'(DUTY_MAX)) ? 10'(DUTY_MAX) : a[9:0];
    endfunction

    function automatic logic [9:0] step_toward(input logic [9:0] cur, input logic [9:0] tgt);
        logic [10:0] c;
        logic [10:0] t;
        c = {1'b0, cur};
        t = {1'b0, tgt};
        if (c < t) return ((t - c) > STEP_W) ? 10'(c + STEP_W) : tgt;
        else       return ((c - t) > STEP_W) ? 10'(c - STEP_W) : tgt;
    endfunction

    assign tick    = (presc_q == PW'(PERIOD_CYC - 1));
    // Command pair transfers on cmd_vld & cmd_rdy; cmd_rdy is simply ~brake, so braking drops commands.
    assign cmd_rdy = ~brake;
    assign accept  = cmd_vld & ~brake;
    assign cmd_a[0] = cmd_lft;
    assign cmd_a[1] = cmd_rht;

    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        settled = '0;
        for (int ch = 0; ch < 2; ch++) begin
            state_d[ch]   = state_q[ch];
            cur_d[ch]     = cur_q[ch];
            rev_d[ch]     = rev_q[ch];
            dcnt_d[ch]    = dcnt_q[ch];
            tgt_dir_d[ch] = tgt_dir_q[ch];
            tgt_mag_d[ch] = tgt_mag_q[ch];
            settled[ch]   = ((state_q[ch] == ST_OFF) && (tgt_mag_q[ch] == 10'd0)) ||
                            ((state_q[ch] == ST_RUN) && (cur_q[ch] == tgt_mag_q[ch]));
            if (brake) begin
                state_d[ch]   = ST_OFF;
                cur_d[ch]     = 10'd0;
                dcnt_d[ch]    = '0;
                tgt_dir_d[ch] = 1'b0;
                tgt_mag_d[ch] = 10'd0;
            end else begin
                if (accept) begin
                    tgt_dir_d[ch] = cmd_a[ch][10];
                    tgt_mag_d[ch] = clamp_mag(cmd_a[ch]);
                end
                // Tick decisions use the registered targets, so an accept on the tick cycle waits one tick.
                if (tick) begin
                    case (state_q[ch])
                        ST_OFF: begin
                            if (tgt_mag_q[ch] != 10'd0) begin
                                state_d[ch] = ST_RUN;
                                rev_d[ch]   = tgt_dir_q[ch];
                                cur_d[ch]   = ({1'b0, tgt_mag_q[ch]} > STEP_W) ? 10'(STEP_W) : tgt_mag_q[ch];
                            end
                        end
                        ST_RUN: begin
                            if ((tgt_dir_q[ch] == rev_q[ch]) && (tgt_mag_q[ch] != 10'd0)) begin
                                cur_d[ch] = step_toward(cur_q[ch], tgt_mag_q[ch]);
                            end else if ({1'b0, cur_q[ch]} <= STEP_W) begin
                                cur_d[ch]   = 10'd0;
                                state_d[ch] = ST_DEAD;
                                dcnt_d[ch]  = DW'(DEAD_TICKS);
                            end else begin
                                cur_d[ch] = 10'(({1'b0, cur_q[ch]}) - STEP_W);
                            end
                        end
                        ST_DEAD: begin
                            if (dcnt_q[ch] == DW'(1)) state_d[ch] = ST_OFF;
                            else                     dcnt_d[ch]  = dcnt_q[ch] - DW'(1);
                        end
                        default: state_d[ch] = ST_OFF;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch]   <= ST_OFF;
                cur_q[ch]     <= 10'd0;
                rev_q[ch]     <= 1'b0;
                dcnt_q[ch]    <= '0;
                tgt_dir_q[ch] <= 1'b0;
                tgt_mag_q[ch] <= 10'd0;
            end
        end else begin
            presc_q <= presc_d;
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch]   <= state_d[ch];
                cur_q[ch]     <= cur_d[ch];
                rev_q[ch]     <= rev_d[ch];
                dcnt_q[ch]    <= dcnt_d[ch];
                tgt_dir_q[ch] <= tgt_dir_d[ch];
                tgt_mag_q[ch] <= tgt_mag_d[ch];
            end
        end
    end

    // Duty 0 would mean 100 % high at the generator, so an idle channel parks at duty 1.
    assign en_lft    = (state_q[0] == ST_RUN);
    assign en_rht    = (state_q[1] == ST_RUN);
    assign duty_lft  = en_lft ? cur_q[0] : 10'd1;
    assign duty_rht  = en_rht ? cur_q[1] : 10'd1;
    assign rev_lft   = rev_q[0];
    assign rev_rht   = rev_q[1];
    assign busy      = ~(&settled);
    assign dbg_state = {state_q[1], state_q[0]};

endmodule

// File: tb/tb_pwm_motor_ctrl.sv
// Randomized bench for pwm_motor_ctrl: a per-cycle reference model queues expected outputs, a monitor compares.
// Runs with a shortened PWM period so ramps to full scale fit the cycle budget.
module tb_pwm_motor_ctrl;
    localparam int P    = 32;
    localparam int DEAD = 4;
    localparam int DMAX = 1022;
`ifdef PWM_MOTOR_CTRL_RAMP_EN
    localparam int M_STEP = 16;
`else
    localparam int M_STEP = 1 << 20;
`endif
    localparam int W = 26;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_vld = 1'b0;
    logic        cmd_rdy;
    logic [10:0] cmd_lft = '0;
    logic [10:0] cmd_rht = '0;
    logic        brake = 1'b0;
    logic [9:0]  duty_lft, duty_rht;
    logic        en_lft, en_rht, rev_lft, rev_rht, busy;
    logic [3:0]  dbg_state;

    pwm_motor_ctrl #(.PERIOD_CYC(P)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .cmd_lft(cmd_lft), .cmd_rht(cmd_rht), .brake(brake),
        .duty_lft(duty_lft), .duty_rht(duty_rht), .en_lft(en_lft), .en_rht(en_rht),
        .rev_lft(rev_lft), .rev_rht(rev_rht), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: one channel is driving (m_on), cooling down (m_cool > 0) or parked.
    int m_on[2], m_cool[2], m_cur[2], m_rev[2], m_tdir[2], m_tmag[2];
    int cyc;
    logic [W-1:0] exp_q[$];
    int chk_cnt = 0;
    int pass_cnt = 0;
    bit prev_ok = 1'b0;
    logic prev_en[2], prev_rev[2];
    int edges[11] = '{0, 1, -1, 16, -16, 1022, 1023, -1024, -1023, 15, 17};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    endtask

    function automatic int clampi(input int x, input int lo, input int hi);
        return (x < lo) ? lo : ((x > hi) ? hi : x);
    endfunction

    function automatic int absi(input int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic model_clear(input bit keep_rev);
        for (int c = 0; c < 2; c++) begin
            m_on[c] = 0; m_cool[c] = 0; m_cur[c] = 0; m_tdir[c] = 0; m_tmag[c] = 0;
            if (!keep_rev) m_rev[c] = 0;
        end
    endtask

    task automatic model_tick(input int c);
        if (m_cool[c] > 0) begin
            m_cool[c]--;
        end else if (m_on[c] == 0) begin
            if (m_tmag[c] > 0) begin
                m_on[c] = 1; m_rev[c] = m_tdir[c];
                m_cur[c] = (m_tmag[c] < M_STEP) ? m_tmag[c] : M_STEP;
            end
        end else if (m_tdir[c] == m_rev[c] && m_tmag[c] > 0) begin
            m_cur[c] += clampi(m_tmag[c] - m_cur[c], -M_STEP, M_STEP);
        end else begin
            m_cur[c] = (m_cur[c] > M_STEP) ? m_cur[c] - M_STEP : 0;
            if (m_cur[c] == 0) begin m_on[c] = 0; m_cool[c] = DEAD; end
        end
    endtask

    function automatic logic [W-1:0] model_out(input bit rdy);
        int d[2];
        bit idle[2];
        for (int c = 0; c < 2; c++) begin
            d[c] = (m_on[c] != 0) ? m_cur[c] : 1;
            idle[c] = (m_on[c] == 0 && m_cool[c] == 0 && m_tmag[c] == 0) ||
                      (m_on[c] != 0 && m_cur[c] == m_tmag[c]);
        end
        return {rdy, !(idle[0] && idle[1]), 1'(m_rev[1]), 1'(m_rev[0]),
                1'(m_on[1]), 1'(m_on[0]), 10'(d[1]), 10'(d[0])};
    endfunction

    // Drive one clock cycle of inputs and queue what the outputs must show after that edge.
    task automatic step(input bit b, input bit v, input int l, input int r);
        bit tk;
        @(negedge clk);
        brake = b; cmd_vld = v; cmd_lft = 11'(l); cmd_rht = 11'(r);
        tk = ((cyc % P) == P - 1);
        if (b) model_clear(1'b1);
        else begin
            if (tk) begin model_tick(0); model_tick(1); end
            if (v) begin
                m_tdir[0] = (l < 0); m_tmag[0] = (absi(l) > DMAX) ? DMAX : absi(l);
                m_tdir[1] = (r < 0); m_tmag[1] = (absi(r) > DMAX) ? DMAX : absi(r);
            end
        end
        cyc++;
        exp_q.push_back(model_out(!b));
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 0, 0);
    endtask

    task automatic to_tick_cycle();
        while ((cyc % P) != P - 1) step(1'b0, 1'b0, 0, 0);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0; brake = 1'b0; cmd_vld = 1'b0; prev_ok = 1'b0;
        #1;
        check("rst_duty_lft", 32'(duty_lft), 32'd1);
        check("rst_duty_rht", 32'(duty_rht), 32'd1);
        check("rst_en", 32'({en_lft, en_rht}), 32'd0);
        check("rst_rev", 32'({rev_lft, rev_rht}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_clear(1'b0);
        cyc = 0;
    endtask

    function automatic int rnd_cmd();
        if ($urandom_range(0, 1) == 1) return edges[$urandom_range(0, 10)];
        return int'($urandom_range(0, 2047)) - 1024;
    endfunction

    always @(posedge clk) begin
        logic [W-1:0] e, g;
        #1;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {cmd_rdy, busy, rev_rht, rev_lft, en_rht, en_lft, duty_rht, duty_lft};
            check("outputs", 32'(g), 32'(e));
            if (prev_ok) begin
                if (rev_lft != prev_rev[0]) check("rev_lft_edge_en", 32'(prev_en[0]), 32'd0);
                if (rev_rht != prev_rev[1]) check("rev_rht_edge_en", 32'(prev_en[1]), 32'd0);
            end
            prev_en[0] = en_lft; prev_en[1] = en_rht;
            prev_rev[0] = rev_lft; prev_rev[1] = rev_rht;
            prev_ok = 1'b1;
        end
    end

    initial begin
        int brk_left;
        bit b;
        cyc = 0;
        model_clear(1'b0);
        apply_reset();

        // Ramp +100 from rest: duty follows the slew table one tick at a time.
        step(1'b0, 1'b1, 100, 0);
        for (int k = 1; k <= 7; k++) begin
            while (cyc < k * P) step(1'b0, 1'b0, 0, 0);
            @(posedge clk);
            #2;
            check("ramp_duty_lft", 32'(duty_lft), 32'((M_STEP * k < 100) ? M_STEP * k : 100));
            check("ramp_en_lft", 32'(en_lft), 32'd1);
        end
        idle(2 * P);

        // Reversal to -50, then full-scale extremes on both channels.
        step(1'b0, 1'b1, -50, 0);
        idle(30 * P);
        step(1'b0, 1'b1, -1024, 1023);
        idle(70 * P);

        // Settle at magnitude 500, then brake three cycles with a command offered mid-brake.
        step(1'b0, 1'b1, -500, 500);
        idle(40 * P);
        step(1'b1, 1'b0, 0, 0);
        @(posedge clk);
        #2;
        check("brake_en_lft", 32'(en_lft), 32'd0);
        check("brake_duty_lft", 32'(duty_lft), 32'd1);
        check("brake_cmd_rdy", 32'(cmd_rdy), 32'd0);
        step(1'b1, 1'b1, 300, 300);
        step(1'b1, 1'b0, 0, 0);
        idle(5 * P);

        // Command accepted on the tick cycle itself only takes effect one tick later.
        to_tick_cycle();
        step(1'b0, 1'b1, 64, 0);
        @(posedge clk);
        #2;
        check("tick_accept_en", 32'(en_lft), 32'd0);
        idle(P);
        @(posedge clk);
        #2;
        check("tick_accept_first", 32'(duty_lft), 32'((M_STEP < 64) ? M_STEP : 64));
        idle(6 * P);

        // Drive left into its dead time, then reset asynchronously.
        step(1'b0, 1'b1, 40, 0);
        idle(5 * P);
        step(1'b0, 1'b1, 0, 0);
        idle(4 * P);
        apply_reset();

        // Random traffic with occasional brakes and boundary-value commands.
        brk_left = 0;
        for (int i = 0; i < 9000; i++) begin
            if (brk_left > 0) begin b = 1'b1; brk_left--; end
            else begin
                b = 1'b0;
                if ($urandom_range(0, 1999) == 0) brk_left = int'($urandom_range(1, 4));
            end
            step(b, ($urandom_range(0, 39) == 0), rnd_cmd(), rnd_cmd());
        end
        idle(2 * P);
        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
